// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM states and reset-cause encoding.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_WAIT_LOCK,
    ST_RELEASE,
    ST_RUN
  } rst_state_e;

  typedef enum logic [2:0] {
    CAUSE_POR  = 3'd0,
    CAUSE_BTN  = 3'd1,
    CAUSE_SW   = 3'd2,
    CAUSE_LOCK = 3'd3,
    CAUSE_WDT  = 3'd4
  } rst_cause_e;

endpackage

// File: rtl/rst_sequencer_sync_ff.sv
// Multi-stage flop synchroniser for asynchronous level inputs, with a configurable reset value.
module sync_ff #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset controller: qualifies the pushbutton, waits for PLL lock, then releases domains in order.
// Optional watchdog is compiled in when RST_SEQ_WDT_EN is defined.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_DOMAINS       = 4,
  parameter int SYNC_STAGES     = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int BTN_HOLD_CYCLES = 500000,
  parameter int STAGE_GAP       = 8,
  parameter int WDT_CYCLES      = 2**24
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 btn_rst_n,
  input  logic                 pll_locked,
  input  logic                 sw_rst_req,
  input  logic                 wdt_kick,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 all_released,
  output logic [2:0]           rst_cause
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int BTN_W  = $clog2(BTN_HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(STAGE_GAP + 1);
  localparam int IDX_W  = $clog2(N_DOMAINS + 1);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BTN_W-1:0]  BTN_MAX  = BTN_W'(BTN_HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_DOMAINS - 1);

  logic btn_s;
  logic lock_s;

  rst_state_e           state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [IDX_W-1:0]     rel_q, rel_d;
  logic [BTN_W-1:0]     btn_cnt_q;
  rst_cause_e           cause_q, cause_d;
  logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                 all_rel_q;

  logic btn_qual;
  logic active;
  logic trig_lock, trig_btn, trig_sw, trig_wdt, trig_any;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_btn_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (btn_rst_n),
    .q     (btn_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Button debounce: any high sample clears the run length; saturates once qualified.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      btn_cnt_q <= '0;
    end else if (btn_s) begin
      btn_cnt_q <= '0;
    end else if (btn_cnt_q != BTN_MAX) begin
      btn_cnt_q <= btn_cnt_q + 1'b1;
    end
  end

  assign btn_qual = !btn_s && (btn_cnt_q == BTN_MAX);

`ifdef RST_SEQ_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wdt_q <= '0;
    end else if ((state_q != ST_RUN) || wdt_kick) begin
      wdt_q <= '0;
    end else if (wdt_q != WDT_MAX) begin
      wdt_q <= wdt_q + 1'b1;
    end
  end

  assign trig_wdt = (state_q == ST_RUN) && !wdt_kick && (wdt_q == WDT_MAX);
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick | (WDT_CYCLES < 1);
  assign trig_wdt   = 1'b0;
`endif

  assign active    = (state_q == ST_RELEASE) || (state_q == ST_RUN);
  assign trig_lock = active && !lock_s;
  assign trig_btn  = active && btn_qual;
  assign trig_sw   = (state_q == ST_RUN) && sw_rst_req;
  assign trig_any  = trig_lock || trig_btn || trig_sw || trig_wdt;

  // rel counts released domains; rst_out is derived from its next value so it stays registered.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    rel_d   = rel_q;
    cause_d = cause_q;
    if (trig_any) begin
      state_d = ST_ASSERT;
      hold_d  = '0;
      gap_d   = '0;
      rel_d   = '0;
      if (trig_lock)     cause_d = CAUSE_LOCK;
      else if (trig_btn) cause_d = CAUSE_BTN;
      else if (trig_sw)  cause_d = CAUSE_SW;
      else               cause_d = CAUSE_WDT;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end else if (!btn_qual) begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            gap_d   = '0;
            rel_d   = IDX_W'(1);
            state_d = (N_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (gap_q == GAP_MAX) begin
            gap_d = '0;
            rel_d = rel_q + 1'b1;
            if (rel_q == LAST_IDX) state_d = ST_RUN;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state_d = ST_ASSERT;
        end
      endcase
    end
  end

  always_comb begin
    rst_out_d = '1;
    for (int i = 0; i < N_DOMAINS; i++) begin
      rst_out_d[i] = (IDX_W'(i) >= rel_d);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_ASSERT;
      hold_q    <= '0;
      gap_q     <= '0;
      rel_q     <= '0;
      cause_q   <= CAUSE_POR;
      rst_out_q <= '1;
      all_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      rel_q     <= rel_d;
      cause_q   <= cause_d;
      rst_out_q <= rst_out_d;
      all_rel_q <= (state_d == ST_RUN);
    end
  end

  assign rst_out      = rst_out_q;
  assign all_released = all_rel_q;
  assign rst_cause    = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: vector table, directed corner cases, randomized run vs model.
// Define RST_SEQ_WDT_EN for both RTL and bench to exercise the watchdog.
module tb_rst_sequencer;

  localparam int N    = 4;
  localparam int SYNC = 3;
  localparam int HOLD = 16;
  localparam int BTN  = 20;
  localparam int GAP  = 8;
  localparam int WDT  = 64;

  localparam int P_ASSERT = 0;
  localparam int P_WAIT   = 1;
  localparam int P_REL    = 2;
  localparam int P_RUN    = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       btn_rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       wdt_kick = 1'b0;
  logic [3:0] rst_out;
  logic       all_released;
  logic [2:0] rst_cause;

  int n_cmp = 0;
  int n_err = 0;

  int m_phase, m_hold_age, m_rel_age, m_btn_low, m_wdt_age, m_cause;
  bit m_btn_s, m_lock_s;
  bit btn_hist[$];
  bit lock_hist[$];

  typedef struct {
    bit         btn;
    bit         lock;
    bit         sw;
    int         ncyc;
    logic [3:0] exp_rst;
    bit         exp_all;
    logic [2:0] exp_cause;
  } vec_t;

  vec_t vecs[$];

  rst_sequencer #(
    .N_DOMAINS       (N),
    .SYNC_STAGES     (SYNC),
    .HOLD_CYCLES     (HOLD),
    .BTN_HOLD_CYCLES (BTN),
    .STAGE_GAP       (GAP),
    .WDT_CYCLES      (WDT)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .btn_rst_n    (btn_rst_n),
    .pll_locked   (pll_locked),
    .sw_rst_req   (sw_rst_req),
    .wdt_kick     (wdt_kick),
    .rst_out      (rst_out),
    .all_released (all_released),
    .rst_cause    (rst_cause)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: phases plus elapsed-time counters; synchronisers are plain delay lines.
  task automatic model_reset();
    m_phase    = P_ASSERT;
    m_hold_age = 0;
    m_rel_age  = 0;
    m_btn_low  = 0;
    m_wdt_age  = 0;
    m_cause    = 0;
    m_btn_s    = 1'b1;
    m_lock_s   = 1'b0;
    btn_hist.delete();
    lock_hist.delete();
    repeat (SYNC - 1) begin
      btn_hist.push_back(1'b1);
      lock_hist.push_back(1'b0);
    end
  endtask

  task automatic model_edge(input bit b, input bit l, input bit s, input bit k);
    bit qual, act, t_lock, t_btn, t_sw, t_wdt;
    int next_wdt;
    qual   = !m_btn_s && (m_btn_low >= BTN - 1);
    act    = (m_phase == P_REL) || (m_phase == P_RUN);
    t_lock = act && !m_lock_s;
    t_btn  = act && qual;
    t_sw   = (m_phase == P_RUN) && s;
    t_wdt  = 1'b0;
`ifdef RST_SEQ_WDT_EN
    t_wdt = (m_phase == P_RUN) && !k && (m_wdt_age >= WDT - 1);
`endif
    next_wdt = ((m_phase != P_RUN) || k) ? 0 : m_wdt_age + 1;
    if (t_lock || t_btn || t_sw || t_wdt) begin
      m_phase    = P_ASSERT;
      m_hold_age = 0;
      m_cause    = t_lock ? 3 : t_btn ? 1 : t_sw ? 2 : 4;
    end else if (m_phase == P_ASSERT) begin
      if (m_hold_age >= HOLD - 1) begin
        if (!qual) m_phase = P_WAIT;
      end else begin
        m_hold_age++;
      end
    end else if (m_phase == P_WAIT) begin
      if (m_lock_s) begin
        m_rel_age = 0;
        m_phase   = (N == 1) ? P_RUN : P_REL;
      end
    end else if (m_phase == P_REL) begin
      m_rel_age++;
      if (m_rel_age >= (N - 1) * GAP) m_phase = P_RUN;
    end
    m_wdt_age = next_wdt;
    m_btn_low = m_btn_s ? 0 : m_btn_low + 1;
    btn_hist.push_back(b);
    lock_hist.push_back(l);
    m_btn_s  = btn_hist.pop_front();
    m_lock_s = lock_hist.pop_front();
  endtask

  function automatic logic [3:0] exp_rst_out();
    int rel;
    logic [3:0] m;
    if (m_phase == P_RUN) return 4'h0;
    if (m_phase != P_REL) return 4'hF;
    rel = 1 + m_rel_age / GAP;
    if (rel > N) rel = N;
    m = 4'hF;
    for (int i = 0; i < N; i++) begin
      if (i < rel) m[i] = 1'b0;
    end
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit b, input bit l, input bit s, input bit k);
    btn_rst_n  = b;
    pll_locked = l;
    sw_rst_req = s;
    wdt_kick   = k;
    @(posedge sys_clk);
    #1;
    model_edge(b, l, s, k);
    checkOutput("cyc_rst_out", 32'(rst_out), 32'(exp_rst_out()));
    checkOutput("cyc_all_released", 32'(all_released), 32'(m_phase == P_RUN));
    checkOutput("cyc_rst_cause", 32'(rst_cause), 32'(m_cause));
  endtask

  task automatic run_to_run(input string name, input int bound);
    int n;
    n = 0;
    while (m_phase != P_RUN && n < bound) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput(name, 32'(all_released), 32'd1);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("reset_rst_out", 32'(rst_out), 32'hF);
    checkOutput("reset_all_released", 32'(all_released), 32'd0);
    checkOutput("reset_rst_cause", 32'(rst_cause), 32'd0);
    pll_locked = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // POR staged release, then debounce behaviour and the button-triggered re-sequence.
    vecs.push_back('{1, 1, 0, 16, 4'hF, 0, 3'd0});
    vecs.push_back('{1, 1, 0, 1,  4'hE, 0, 3'd0});
    vecs.push_back('{1, 1, 0, 7,  4'hE, 0, 3'd0});
    vecs.push_back('{1, 1, 0, 1,  4'hC, 0, 3'd0});
    vecs.push_back('{1, 1, 0, 8,  4'h8, 0, 3'd0});
    vecs.push_back('{1, 1, 0, 8,  4'h0, 1, 3'd0});
    vecs.push_back('{0, 1, 0, 19, 4'h0, 1, 3'd0});
    vecs.push_back('{1, 1, 0, 1,  4'h0, 1, 3'd0});
    vecs.push_back('{0, 1, 0, 19, 4'h0, 1, 3'd0});
    vecs.push_back('{1, 1, 0, 1,  4'h0, 1, 3'd0});
    vecs.push_back('{0, 1, 0, 20, 4'h0, 1, 3'd0});
    vecs.push_back('{1, 1, 0, 2,  4'h0, 1, 3'd0});
    vecs.push_back('{1, 1, 0, 1,  4'hF, 0, 3'd1});
    vecs.push_back('{1, 1, 0, 16, 4'hF, 0, 3'd1});
    vecs.push_back('{1, 1, 0, 1,  4'hE, 0, 3'd1});
    vecs.push_back('{1, 1, 0, 24, 4'h0, 1, 3'd1});

    foreach (vecs[i]) begin
      repeat (vecs[i].ncyc) applyStimulus(vecs[i].btn, vecs[i].lock, vecs[i].sw, 1'b0);
      checkOutput($sformatf("vec%0d_rst_out", i), 32'(rst_out), 32'(vecs[i].exp_rst));
      checkOutput($sformatf("vec%0d_all_released", i), 32'(all_released), 32'(vecs[i].exp_all));
      checkOutput($sformatf("vec%0d_rst_cause", i), 32'(rst_cause), 32'(vecs[i].exp_cause));
    end

    // Software request in RUN.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("sw_run_rst_out", 32'(rst_out), 32'hF);
    checkOutput("sw_run_cause", 32'(rst_cause), 32'd2);

    // Lock loss while rst_out is 4'hC.
    n = 0;
    while (exp_rst_out() != 4'hC && n < 200) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput("reach_C", 32'(rst_out), 32'hC);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lock_drop_pending", 32'(rst_out), 32'hC);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lock_drop_rst_out", 32'(rst_out), 32'hF);
    checkOutput("lock_drop_cause", 32'(rst_cause), 32'd3);

    // Software request while waiting for lock is ignored; relock latency unchanged.
    n = 0;
    while (m_phase != P_WAIT && n < 60) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("wait_lock_reached", 32'(m_phase == P_WAIT && rst_out == 4'hF), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("sw_wait_cause", 32'(rst_cause), 32'd3);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("relock_pending", 32'(rst_out), 32'hF);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("relock_latency", 32'(rst_out), 32'hE);
    run_to_run("relock_run", 100);

    // Button qualifies on the same edge as a software request: button wins.
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("btn_sw_pending", 32'(all_released), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("btn_sw_rst_out", 32'(rst_out), 32'hF);
    checkOutput("btn_sw_cause", 32'(rst_cause), 32'd1);
    run_to_run("btn_sw_run", 100);

    // Button held for 200 cycles keeps everything in reset; release restarts the sequence.
    repeat (200) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("held_rst_out", 32'(rst_out), 32'hF);
    checkOutput("held_cause", 32'(rst_cause), 32'd1);
    n = 0;
    while (all_released !== 1'b1 && n < 100) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput("held_release_latency", 32'(n), 32'd29);

`ifdef RST_SEQ_WDT_EN
    repeat (63) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("wdt_pending", 32'(all_released), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("wdt_rst_out", 32'(rst_out), 32'hF);
    checkOutput("wdt_cause", 32'(rst_cause), 32'd4);
    run_to_run("wdt_rerun", 100);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b1, 1'b0, (i % 50) == 49);
    checkOutput("wdt_kicked", 32'(all_released), 32'd1);
`endif

    // Randomized traffic: button bursts, lock dropouts, software requests, kicks.
    begin
      int btn_left;
      int lock_left;
      bit b, l, s, k;
      btn_left  = 0;
      lock_left = 0;
      for (int c = 0; c < 3000; c++) begin
        if (btn_left > 0) begin
          b = 1'b0;
          btn_left--;
        end else begin
          b = 1'b1;
          if ($urandom_range(0, 99) == 0) btn_left = $urandom_range(1, 40);
        end
        if (lock_left > 0) begin
          l = 1'b0;
          lock_left--;
        end else begin
          l = 1'b1;
          if ($urandom_range(0, 399) == 0) lock_left = $urandom_range(1, 8);
        end
        s = ($urandom_range(0, 59) == 0);
        k = ($urandom_range(0, 19) == 0);
        applyStimulus(b, l, s, k);
      end
    end

    // sys_rst_n clears the recorded cause asynchronously.
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    run_to_run("pre_por_run", 200);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("pre_por_cause", 32'(rst_cause), 32'd2);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #2;
    checkOutput("async_rst_out", 32'(rst_out), 32'hF);
    checkOutput("async_all_released", 32'(all_released), 32'd0);
    checkOutput("async_rst_cause", 32'(rst_cause), 32'd0);
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run_to_run("post_por_run", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
